// File: rtl/seq_mult.sv
// Sequential radix-2 Booth multiplier: one Booth step per cycle, WIDTH+1 steps
// per operation, signed or unsigned operands selected per request.
//
// state | meaning
// IDLE  | waiting for start; result registers hold the last product
// RUN   | Booth step each cycle; the last step writes the result and pulses done
module seq_mult #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] high,
  output logic [WIDTH-1:0] low,
  output logic             ovf
);

  localparam int W1 = WIDTH + 1;
  localparam int CW = $clog2(WIDTH + 2);

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state, state_nxt;
  logic [W1-1:0]   mcand;
  logic [W1-1:0]   p_hi;
  logic [W1-1:0]   p_lo;
  logic            q;
  logic [CW-1:0]   cnt;
  logic            sgn;

  logic [W1-1:0]   ext_a, ext_b;
  logic [W1-1:0]   sum_hi;
  logic [W1-1:0]   sh_hi, sh_lo;
  logic            sh_q;
  logic [2*W1-1:0] product;
  logic [WIDTH-1:0] res_hi, res_lo;
  logic            last_step;

  // The extra bit keeps unsigned operands positive inside the signed Booth datapath.
  assign ext_a = {is_signed & a[WIDTH-1], a};
  assign ext_b = {is_signed & b[WIDTH-1], b};

  always_comb begin
    sum_hi = p_hi;
    case ({p_lo[0], q})
      2'b01:   sum_hi = p_hi + mcand;
      2'b10:   sum_hi = p_hi - mcand;
      default: sum_hi = p_hi;
    endcase
  end

  assign {sh_hi, sh_lo, sh_q} = {sum_hi[W1-1], sum_hi, p_lo};
  assign product   = {sh_hi, sh_lo};
  assign res_hi    = product[2*WIDTH-1:WIDTH];
  assign res_lo    = product[WIDTH-1:0];
  assign last_step = (cnt == CW'(1));
  assign busy      = (state == RUN);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last_step) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mcand <= '0;
      p_hi  <= '0;
      p_lo  <= '0;
      q     <= 1'b0;
      cnt   <= '0;
      sgn   <= 1'b0;
      done  <= 1'b0;
      high  <= '0;
      low   <= '0;
      ovf   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mcand <= ext_a;
            p_hi  <= '0;
            p_lo  <= ext_b;
            q     <= 1'b0;
            cnt   <= CW'(W1);
            sgn   <= is_signed;
          end
        end
        RUN: begin
          p_hi <= sh_hi;
          p_lo <= sh_lo;
          q    <= sh_q;
          cnt  <= cnt - CW'(1);
          if (last_step) begin
            high <= res_hi;
            low  <= res_lo;
            done <= 1'b1;
            if (sgn) ovf <= (res_hi != {WIDTH{res_lo[WIDTH-1]}});
            else     ovf <= (res_hi != '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mult.sv
// Directed self-checking bench for seq_mult (WIDTH=32) with hand-computed products.
module tb_seq_mult;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        is_signed;
  logic [31:0] a, b;
  logic        busy, done, ovf;
  logic [31:0] high, low;

  int n_checks = 0;
  int n_fail   = 0;

  seq_mult #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .is_signed(is_signed),
    .a(a), .b(b), .busy(busy), .done(done), .high(high), .low(low), .ovf(ovf)
  );

  always #5 clk = ~clk;

  // Issues one request and returns at #1 after the edge where done rises.
  // lat = edges from the sampling edge to done (100 = timed out).
  // busy_ok = busy high in every cycle before done and low in the done cycle.
  task automatic run_op(input logic sg, input logic [31:0] av, input logic [31:0] bv,
                        input bit immediate, output int lat, output bit busy_ok);
    if (!immediate) @(negedge clk);
    start = 1'b1; is_signed = sg; a = av; b = bv;
    @(posedge clk); #1;
    start = 1'b0;
    busy_ok = 1'b1;
    lat = 100;
    for (int i = 1; i <= 100; i++) begin
      if (!busy) busy_ok = 1'b0;
      @(posedge clk); #1;
      if (done) begin
        lat = i;
        if (busy) busy_ok = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; is_signed = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (busy !== 1'b0)  begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_checks++; if (done !== 1'b0)  begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
    n_checks++; if (high !== 32'h0) begin n_fail++; $display("FAIL reset_high got %h want 0", high); end
    n_checks++; if (low !== 32'h0)  begin n_fail++; $display("FAIL reset_low got %h want 0", low); end
    n_checks++; if (ovf !== 1'b0)   begin n_fail++; $display("FAIL reset_ovf got %b want 0", ovf); end
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_signed;
    int lat; bit bok;
    run_op(1'b1, 32'hFFFF_FFFD, 32'h0000_0007, 1'b0, lat, bok);
    n_checks++; if (lat != 33)  begin n_fail++; $display("FAIL signed_latency got %0d want 33", lat); end
    n_checks++; if (!bok)       begin n_fail++; $display("FAIL signed_busy got bad profile want high-then-low"); end
    n_checks++; if (high !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL signed_high got %h want ffffffff", high); end
    n_checks++; if (low !== 32'hFFFF_FFEB)  begin n_fail++; $display("FAIL signed_low got %h want ffffffeb", low); end
    n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL signed_ovf got %b want 0", ovf); end
    a = 32'h1234_5678; b = 32'h9ABC_DEF0;
    repeat (3) begin
      @(posedge clk); #1;
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL done_one_cycle got %b want 0", done); end
    end
    n_checks++; if (low !== 32'hFFFF_FFEB) begin n_fail++; $display("FAIL result_hold got %h want ffffffeb", low); end
  endtask

  task automatic test_unsigned;
    int lat; bit bok;
    run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, lat, bok);
    n_checks++; if (lat != 33) begin n_fail++; $display("FAIL unsigned_latency got %0d want 33", lat); end
    n_checks++; if (high !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL unsigned_high got %h want fffffffe", high); end
    n_checks++; if (low !== 32'h0000_0001)  begin n_fail++; $display("FAIL unsigned_low got %h want 00000001", low); end
    n_checks++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL unsigned_ovf got %b want 1", ovf); end
  endtask

  task automatic test_signed_edge;
    int lat; bit bok;
    run_op(1'b1, 32'h8000_0000, 32'h8000_0000, 1'b0, lat, bok);
    n_checks++; if (high !== 32'h4000_0000) begin n_fail++; $display("FAIL min_sq_high got %h want 40000000", high); end
    n_checks++; if (low !== 32'h0) begin n_fail++; $display("FAIL min_sq_low got %h want 00000000", low); end
    n_checks++; if (ovf !== 1'b1)  begin n_fail++; $display("FAIL min_sq_ovf got %b want 1", ovf); end
    run_op(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, lat, bok);
    n_checks++; if (high !== 32'h0) begin n_fail++; $display("FAIL neg1_sq_high got %h want 0", high); end
    n_checks++; if (low !== 32'h1)  begin n_fail++; $display("FAIL neg1_sq_low got %h want 1", low); end
    n_checks++; if (ovf !== 1'b0)   begin n_fail++; $display("FAIL neg1_sq_ovf got %b want 0", ovf); end
  endtask

  task automatic test_reset_mid;
    int lat; bit bok; bit seen;
    seen = 1'b0;
    @(negedge clk);
    start = 1'b1; is_signed = 1'b0; a = 32'd5; b = 32'd6;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      if (done) seen = 1'b1;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (busy !== 1'b0)  begin n_fail++; $display("FAIL abort_busy got %b want 0", busy); end
    n_checks++; if (high !== 32'h0 || low !== 32'h0 || ovf !== 1'b0)
      begin n_fail++; $display("FAIL abort_outputs got %h_%h ovf %b want 0_0 ovf 0", high, low, ovf); end
    @(negedge clk); reset = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) seen = 1'b1;
    end
    n_checks++; if (seen) begin n_fail++; $display("FAIL abort_no_done got done want none"); end
    run_op(1'b0, 32'd5, 32'd6, 1'b0, lat, bok);
    n_checks++; if (lat != 33) begin n_fail++; $display("FAIL restart_latency got %0d want 33", lat); end
    n_checks++; if (low !== 32'h0000_001E || high !== 32'h0)
      begin n_fail++; $display("FAIL restart_result got %h_%h want 00000000_0000001e", high, low); end
  endtask

  task automatic test_ignore_busy;
    int ndone;
    ndone = 0;
    @(negedge clk);
    start = 1'b1; is_signed = 1'b0; a = 32'd2; b = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 1; i <= 80; i++) begin
      if (i == 5) begin start = 1'b1; a = 32'd9; b = 32'd9; is_signed = 1'b1; end
      if (i == 6) start = 1'b0;
      @(posedge clk); #1;
      if (done) ndone++;
    end
    n_checks++; if (ndone != 1) begin n_fail++; $display("FAIL busy_start_dones got %0d want 1", ndone); end
    n_checks++; if (low !== 32'd6 || high !== 32'h0)
      begin n_fail++; $display("FAIL busy_start_result got %h_%h want 00000000_00000006", high, low); end
  endtask

  task automatic test_back_to_back;
    int lat; bit bok;
    run_op(1'b0, 32'd12, 32'd13, 1'b0, lat, bok);
    n_checks++; if (low !== 32'h0000_009C || high !== 32'h0)
      begin n_fail++; $display("FAIL b2b_first got %h_%h want 00000000_0000009c", high, low); end
    run_op(1'b1, 32'hFFFF_FFFE, 32'd5, 1'b1, lat, bok);
    n_checks++; if (lat != 33) begin n_fail++; $display("FAIL b2b_latency got %0d want 33", lat); end
    n_checks++; if (!bok)      begin n_fail++; $display("FAIL b2b_busy got gap want continuous busy"); end
    n_checks++; if (high !== 32'hFFFF_FFFF || low !== 32'hFFFF_FFF6 || ovf !== 1'b0)
      begin n_fail++; $display("FAIL b2b_second got %h_%h ovf %b want ffffffff_fffffff6 ovf 0", high, low, ovf); end
  endtask

  initial begin
    test_reset();
    test_signed();
    test_unsigned();
    test_signed_edge();
    test_reset_mid();
    test_ignore_busy();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_mult.md
SEQ_MULT -- requirements
Module: seq_mult

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width in bits; legal range 4..64.
REQ-002 SHALL have port clk  input  1  clock; all state changes on the rising edge.
REQ-003 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port start  input  1  request a multiply; sampled only in IDLE.
REQ-005 SHALL have port is_signed  input  1  1 = two's-complement operands, 0 = unsigned; sampled with start.
REQ-006 SHALL have port a  input  WIDTH  multiplicand; sampled with start.
REQ-007 SHALL have port b  input  WIDTH  multiplier; sampled with start.
REQ-008 SHALL have port busy  output  1  high while an operation is in progress.
REQ-009 SHALL have port done  output  1  one-cycle completion pulse.
REQ-010 SHALL have port high  output  WIDTH  upper half of the 2*WIDTH product.
REQ-011 SHALL have port low  output  WIDTH  lower half of the 2*WIDTH product.
REQ-012 SHALL have port ovf  output  1  product does not fit in low alone.

Function
REQ-013 SHALL implement states IDLE and RUN.
REQ-014 In IDLE with start=1, SHALL latch a, b and is_signed, enter RUN, and load the step counter with WIDTH+1.
REQ-015 SHALL extend both operands to WIDTH+1 bits before the operation: sign-extend when is_signed=1, zero-extend when is_signed=0.
REQ-016 SHALL use radix-2 Booth recoding with one step per RUN cycle.
- Accumulator layout: {P_hi[WIDTH+1], P_lo[WIDTH+1], q_-1}.
- Bit pair 01: add the multiplicand into P_hi; bit pair 10: subtract it; 00 and 11: no change.
- Each step then performs an arithmetic right shift by 1 that preserves the sign bit.
REQ-017 SHALL perform exactly WIDTH+1 Booth steps per operation.
REQ-018 On the final step, SHALL take the result from the low 2*WIDTH bits of the (P_hi,P_lo) product, write high and low, pulse done=1, and return to IDLE.
REQ-019 Latency: if start is sampled at edge E0, done SHALL be high in the cycle after edge E0+WIDTH+1 (33 cycles for WIDTH=32).
REQ-020 busy SHALL be 1 from the cycle after E0 through the last RUN cycle, and 0 in the done cycle.
REQ-021 done SHALL be high for exactly one cycle per completed operation.
REQ-022 start asserted while busy=1 SHALL be ignored; the latched operands SHALL NOT change.
REQ-023 start asserted during the done cycle SHALL be accepted (back-to-back operation), because the state is IDLE.
REQ-024 high, low and ovf SHALL hold their values until the next completion or reset.
REQ-025 Changes on a, b or is_signed during RUN SHALL NOT affect the result.
REQ-026 ovf SHALL be written at completion:
- signed: ovf = (high != all copies of low[WIDTH-1]);
- unsigned: ovf = (high != 0).
REQ-027 All arithmetic SHALL be modulo the accumulator width; there are no error states.

Reset
REQ-028 While reset=1, SHALL set state=IDLE, busy=0, done=0, high=0, low=0, ovf=0, and clear the counter and accumulator.
REQ-029 Reset SHALL take priority over start and over any in-progress step.
REQ-030 Reset during RUN SHALL abort the operation with no done pulse; the next operation SHALL start cleanly.

Verification (WIDTH=32)
REQ-031 Signed multiply: is_signed=1, a=FFFFFFFD, b=00000007 -> high=FFFFFFFF, low=FFFFFFEB, ovf=0, done 33 cycles after start.
REQ-032 Unsigned multiply: is_signed=0, a=b=FFFFFFFF -> high=FFFFFFFE, low=00000001, ovf=1.
REQ-033 Signed edge case: is_signed=1, a=b=80000000 -> high=40000000, low=00000000, ovf=1; and a=b=FFFFFFFF signed -> high=0, low=1, ovf=0.
REQ-034 Reset mid-operation: start 5*6, assert reset at cycle 10 -> no done, outputs 0; a new start 5*6 -> low=0000001E, high=0.
REQ-035 Start ignored while busy: start 2*3, pulse start with 9*9 at cycle 5 -> only one done, low=6.
REQ-036 Back-to-back: start asserted in the done cycle -> second done exactly 33 cycles later, busy never low between the two operations except in the done cycle.
